// File: rtl/systolic_act_skewer.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_act_skewer
//  Brief    : Activation feeder for a weight-stationary systolic array.
//             Accepts one unskewed activation column per cycle and emits it
//             diagonally skewed (lane r delayed r cycles). After the last
//             vector of a tile it flushes zeros and pulses done when the
//             final word leaves the bottom lane.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_act_skewer #(
  parameter int ARR_HEIGHT = 8,
  parameter int WORD_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_WIDTH*ARR_HEIGHT-1:0] in_vec,
  input  logic                             in_last,
  output logic [WORD_WIDTH*ARR_HEIGHT-1:0] a_out_vec,
  output logic [ARR_HEIGHT-1:0]            a_out_lane_vld,
  output logic                             busy,
  output logic                             done
);

  // Drain counter must hold ARR_HEIGHT-1; keep at least one bit.
  localparam int                 C_CNT_W    = (ARR_HEIGHT > 1) ? $clog2(ARR_HEIGHT) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(ARR_HEIGHT - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept;

  // in_ready is a registered Moore output, so accept never depends on
  // combinational paths through this block.
  assign accept   = in_valid && in_ready_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Next-state, drain counter and next Moore outputs of the tile controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_d = S_DRAIN;
            cnt_d   = C_CNT_INIT;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are computed from the next state so they are registered yet
    // still describe the state the block occupies in the following cycle.
    in_ready_d = (state_d != S_DRAIN);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DRAIN) && (cnt_d == '0);
  end

  // Tile controller state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // One shift chain per lane; lane r holds r+1 stages so its tail lags
  // lane 0 by r cycles. Chains never stall: the array cannot push back.
  for (genvar r = 0; r < ARR_HEIGHT; r++) begin : g_lane
    localparam int DEPTH = r + 1;

    logic [WORD_WIDTH-1:0]       head_data;
    logic [DEPTH*WORD_WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            vld_q, vld_d;

    // Head loads real data only on accept; otherwise it injects a bubble.
    assign head_data = accept ? in_vec[r*WORD_WIDTH +: WORD_WIDTH] : '0;

    if (DEPTH == 1) begin : g_no_skew
      // Single-stage lane: the head register is also the tail.
      always_comb begin
        data_d = head_data;
        vld_d  = accept;
      end
    end else begin : g_skew
      // Shift toward the MSB slot; the MSB slot is the chain tail.
      always_comb begin
        data_d = {data_q[(DEPTH-1)*WORD_WIDTH-1:0], head_data};
        vld_d  = {vld_q[DEPTH-2:0], accept};
      end
    end

    // Lane stage registers, cleared asynchronously so outputs drop at once.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q <= '0;
        vld_q  <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign a_out_vec[r*WORD_WIDTH +: WORD_WIDTH] = data_q[DEPTH*WORD_WIDTH-1 -: WORD_WIDTH];
    assign a_out_lane_vld[r]                     = vld_q[DEPTH-1];
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_act_skewer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_act_skewer
//  Brief    : Scoreboard bench for systolic_act_skewer, exercising a
//             4-row instance and a 1-row instance with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_act_skewer;

  typedef struct {
    int         cyc;
    int         lane;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  // 4-row instance
  logic        in_valid4, in_ready4, in_last4, busy4, done4;
  logic [31:0] in_vec4, a_out4;
  logic [3:0]  vld4;
  // 1-row instance
  logic        in_valid1, in_ready1, in_last1, busy1, done1;
  logic [7:0]  in_vec1, a_out1;
  logic [0:0]  vld1;

  exp_t e4[$];
  int   d4[$];
  exp_t e1[$];
  int   d1[$];

  systolic_act_skewer #(.ARR_HEIGHT(4), .WORD_WIDTH(8)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_vec(in_vec4), .in_last(in_last4), .a_out_vec(a_out4),
    .a_out_lane_vld(vld4), .busy(busy4), .done(done4)
  );

  systolic_act_skewer #(.ARR_HEIGHT(1), .WORD_WIDTH(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_vec(in_vec1), .in_last(in_last1), .a_out_vec(a_out1),
    .a_out_lane_vld(vld1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: actual still running, required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector to the 4-row DUT; returns the accept cycle.
  task automatic send4(input logic [31:0] v, input logic last, output int k);
    int waited;
    waited = 0;
    k = -1;
    in_valid4 = 1'b1; in_vec4 = v; in_last4 = last;
    forever begin
      @(negedge clk);
      if (in_ready4) begin k = cyc; break; end
      waited++;
      if (waited > 40) begin
        n_tests++; n_fail++;
        $display("FAIL send4_accept_timeout: actual no accept, required accept within 40 cycles");
        break;
      end
    end
    if (k >= 0) begin
      for (int r = 0; r < 4; r++) e4.push_back('{cyc: k + 1 + r, lane: r, data: v[r*8 +: 8]});
      if (last) d4.push_back(k + 4);
    end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0; in_vec4 = '0; in_last4 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] v, input logic last, output int k);
    int waited;
    waited = 0;
    k = -1;
    in_valid1 = 1'b1; in_vec1 = v; in_last1 = last;
    forever begin
      @(negedge clk);
      if (in_ready1) begin k = cyc; break; end
      waited++;
      if (waited > 40) begin
        n_tests++; n_fail++;
        $display("FAIL send1_accept_timeout: actual no accept, required accept within 40 cycles");
        break;
      end
    end
    if (k >= 0) begin
      e1.push_back('{cyc: k + 1, lane: 0, data: v});
      if (last) d1.push_back(k + 1);
    end
    @(posedge clk);
    #1;
    in_valid1 = 1'b0; in_vec1 = '0; in_last1 = 1'b0;
  endtask

  task automatic wait_idle4();
    int n;
    n = 0;
    while (!(in_ready4 && !busy4)) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        n_tests++; n_fail++;
        $display("FAIL wait_idle4_timeout: actual busy, required idle within 40 cycles");
        break;
      end
    end
    tick();
  endtask

  // Scoreboard monitor for the 4-row instance.
  always @(negedge clk) begin
    int i, f;
    logic [7:0] d;
    i = 0;
    while (i < e4.size()) begin
      if (e4[i].cyc < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL lane%0d_missing: actual no valid word, required 0x%02h in cycle %0d",
                 e4[i].lane, e4[i].data, e4[i].cyc);
        e4.delete(i);
      end else i++;
    end
    for (int r = 0; r < 4; r++) begin
      d = a_out4[r*8 +: 8];
      n_tests++;
      if (vld4[r]) begin
        f = -1;
        for (int j = 0; j < e4.size(); j++) if (f < 0 && e4[j].lane == r) f = j;
        if (f < 0) begin
          n_fail++;
          $display("FAIL lane%0d_unexpected: actual 0x%02h valid in cycle %0d, required invalid", r, d, cyc);
        end else begin
          if (e4[f].cyc != cyc || e4[f].data != d) begin
            n_fail++;
            $display("FAIL lane%0d_word: actual 0x%02h in cycle %0d, required 0x%02h in cycle %0d",
                     r, d, cyc, e4[f].data, e4[f].cyc);
          end
          e4.delete(f);
        end
      end else if (d != 8'h00) begin
        n_fail++;
        $display("FAIL lane%0d_idle_data: actual 0x%02h in cycle %0d, required 0x00", r, d, cyc);
      end
    end
    while (d4.size() > 0 && d4[0] < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL done4_missing: actual no pulse, required pulse in cycle %0d", d4[0]);
      void'(d4.pop_front());
    end
    if (done4) begin
      n_tests++;
      if (d4.size() == 0) begin
        n_fail++;
        $display("FAIL done4_unexpected: actual pulse in cycle %0d, required none", cyc);
      end else begin
        if (d4[0] != cyc) begin
          n_fail++;
          $display("FAIL done4_timing: actual cycle %0d, required cycle %0d", cyc, d4[0]);
        end
        void'(d4.pop_front());
      end
    end
  end

  // Scoreboard monitor for the 1-row instance.
  always @(negedge clk) begin
    while (e1.size() > 0 && e1[0].cyc < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL u1_missing: actual no valid word, required 0x%02h in cycle %0d", e1[0].data, e1[0].cyc);
      void'(e1.pop_front());
    end
    n_tests++;
    if (vld1[0]) begin
      if (e1.size() == 0) begin
        n_fail++;
        $display("FAIL u1_unexpected: actual 0x%02h in cycle %0d, required invalid", a_out1, cyc);
      end else begin
        if (e1[0].cyc != cyc || e1[0].data != a_out1) begin
          n_fail++;
          $display("FAIL u1_word: actual 0x%02h in cycle %0d, required 0x%02h in cycle %0d",
                   a_out1, cyc, e1[0].data, e1[0].cyc);
        end
        void'(e1.pop_front());
      end
    end else if (a_out1 != 8'h00) begin
      n_fail++;
      $display("FAIL u1_idle_data: actual 0x%02h in cycle %0d, required 0x00", a_out1, cyc);
    end
    while (d1.size() > 0 && d1[0] < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL done1_missing: actual no pulse, required pulse in cycle %0d", d1[0]);
      void'(d1.pop_front());
    end
    if (done1) begin
      n_tests++;
      if (d1.size() == 0 || d1[0] != cyc) begin
        n_fail++;
        $display("FAIL done1_timing: actual pulse in cycle %0d, required cycle %0d", cyc,
                 (d1.size() == 0) ? -1 : d1[0]);
      end
      if (d1.size() > 0) void'(d1.pop_front());
    end
  end

  initial begin
    int k, k1, k2, k3, ka, kb, kc, kd, ke;
    logic [31:0] v;

    reset_n = 1'b0;
    in_valid4 = 1'b0; in_vec4 = '0; in_last4 = 1'b0;
    in_valid1 = 1'b0; in_vec1 = '0; in_last1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_a_out4", a_out4, 0);
    chk("rst_vld4", vld4, 0);
    chk("rst_in_ready4", in_ready4, 1);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_in_ready1", in_ready1, 1);
    reset_n = 1'b1;
    tick();

    // 1: single vector with last
    send4(32'h44332211, 1'b1, k1);
    chk("t1_busy_drain", busy4, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("t1_in_ready_c%0d", i), in_ready4, 0);
    end
    @(negedge clk);
    chk("t1_in_ready_after", in_ready4, 1);
    chk("t1_busy_after", busy4, 0);
    tick();

    // 2: three streamed vectors, lane r of vector v = 0x10*v + r
    for (int vv = 1; vv <= 3; vv++) begin
      for (int r = 0; r < 4; r++) v[r*8 +: 8] = 8'(16 * vv + r);
      if (vv == 1) send4(v, 1'b0, k1);
      else if (vv == 2) send4(v, 1'b0, k2);
      else send4(v, 1'b1, k3);
    end
    chk("t2_back_to_back", k3 - k1, 2);
    wait_idle4();

    // 3: bubble between two vectors; in_last without in_valid is ignored
    send4(32'hA3A2A1A0, 1'b0, ka);
    in_last4 = 1'b1;
    tick();
    in_last4 = 1'b0;
    chk("t3_stream_busy", busy4, 1);
    chk("t3_stream_ready", in_ready4, 1);
    send4(32'hB3B2B1B0, 1'b1, kb);
    chk("t3_gap", kb - ka, 2);
    wait_idle4();

    // 4: held valid during drain waits until k+5
    send4(32'hC3C2C1C0, 1'b1, kc);
    send4(32'hD3D2D1D0, 1'b0, kd);
    chk("t4_accept_after_drain", kd - kc, 5);
    send4(32'hE3E2E1E0, 1'b1, ke);
    chk("t4_next_tile", ke - kd, 1);
    wait_idle4();

    // 5: asynchronous reset mid-drain
    send4(32'hF3F2F1F0, 1'b1, k);
    tick();
    #1;
    reset_n = 1'b0;
    e4.delete();
    d4.delete();
    #1;
    chk("t5_a_out4", a_out4, 0);
    chk("t5_vld4", vld4, 0);
    chk("t5_in_ready4", in_ready4, 1);
    chk("t5_busy4", busy4, 0);
    chk("t5_done4", done4, 0);
    tick();
    reset_n = 1'b1;
    tick();
    send4(32'h0F0E0D0C, 1'b1, k);
    wait_idle4();

    // 6: single-row instance
    send1(8'hA5, 1'b1, k);
    chk("t6_in_ready_drain", in_ready1, 0);
    chk("t6_busy_drain", busy1, 1);
    tick();
    chk("t6_in_ready_idle", in_ready1, 1);
    chk("t6_busy_idle", busy1, 0);
    send1(8'h3C, 1'b0, ka);
    send1(8'hC3, 1'b1, kb);
    chk("t6_stream", kb - ka, 1);

    repeat (8) tick();
    chk("end_e4_empty", e4.size(), 0);
    chk("end_d4_empty", d4.size(), 0);
    chk("end_e1_empty", e1.size(), 0);
    chk("end_d1_empty", d1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_act_skewer.md
Name: systolic_act_skewer

Overview:
- Activation feeder that sits directly upstream of the weight-stationary systolic array's activation input (a_in_vec).
- Accepts one unskewed activation column vector per cycle, one word per array row, over a valid/ready handshake.
- Emits the vector diagonally skewed: row r is delayed r cycles relative to row 0, so the array's partial sums line up down each column.
- After the last vector of a tile it flushes zeros until the final word has left row ARR_HEIGHT-1, then pulses done.

Parameters:
ARR_HEIGHT  8  number of array rows = number of activation lanes
WORD_WIDTH  8  bits per activation word

Ports:
clk            in   1                      global clock, rising edge
reset_n        in   1                      global reset, asynchronous, active-low
in_valid       in   1                      in_vec/in_last valid this cycle
in_ready       out  1                      skewer can accept this cycle
in_vec         in   WORD_WIDTH*ARR_HEIGHT  unskewed activations; lane r = bits [(r+1)*WORD_WIDTH-1 : r*WORD_WIDTH]
in_last        in   1                      this vector is the final one of the tile
a_out_vec      out  WORD_WIDTH*ARR_HEIGHT  skewed activations to array a_in_vec, same lane packing
a_out_lane_vld out  ARR_HEIGHT             bit r = lane r of a_out_vec carries real (accepted) data
busy           out  1                      state is STREAM or DRAIN
done           out  1                      one-cycle pulse when the last vector's word exits lane ARR_HEIGHT-1

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: all lane registers are 0, and a_out_vec = 0, a_out_lane_vld = 0. State = IDLE, drain counter = 0, in_ready = 1, busy = 0, done = 0.
- Accept: accept = in_valid && in_ready.
- Lane pipelines:
  - Lane r is a shift chain of r+1 registers, holding data plus a valid bit. a_out_vec lane r is the chain tail.
  - Every chain shifts every cycle; there is no stall, because the array has no backpressure.
  - The chain head loads in_vec lane r with valid=1 when accept, else 0 with valid=0.
- Latency: a vector accepted in cycle k appears on lane r during cycle k+1+r. All other cycles output 0 with valid bit 0.
- Bubbles: in_valid=0 in STREAM inserts a zero column; the data sequence is preserved with gaps.
- State machine (registered, Moore outputs):
  - IDLE: in_ready=1. Accept with in_last=0 -> STREAM. Accept with in_last=1 -> DRAIN, counter <= ARR_HEIGHT-1.
  - STREAM: in_ready=1. Accept with in_last=1 -> DRAIN, counter <= ARR_HEIGHT-1. Otherwise stay.
  - DRAIN: in_ready=0; heads load zeros. done = (counter==0). If counter==0 -> IDLE, else counter decrements.
- Drain timing: if the last vector is accepted in cycle k, DRAIN occupies cycles k+1..k+ARR_HEIGHT. done is high in cycle k+ARR_HEIGHT, coincident with a_out_lane_vld[ARR_HEIGHT-1]=1 carrying that vector. IDLE resumes in cycle k+ARR_HEIGHT+1.
- Counter sizing: the counter is wide enough for ARR_HEIGHT-1, with a minimum of 1 bit.
- ARR_HEIGHT=1: no skew (one register). DRAIN lasts 1 cycle; done is in cycle k+1.
- Back-to-back tiles: a new tile cannot be accepted during DRAIN. The first accept of the next tile occurs at the earliest in cycle k+ARR_HEIGHT+1, so consecutive tiles do not overlap in the array.
- in_last while in_valid=0 is ignored.
- Data bits are passed unmodified; no arithmetic is performed.
- Reset mid-operation: all chains clear immediately, state returns to IDLE, and done is not pulsed.

Test Plan:
1. ARR_HEIGHT=4, WORD_WIDTH=8. Accept a single vector {0x44,0x33,0x22,0x11} (lane3..lane0) with in_last=1 in cycle 0. Required:
   - lane0=0x11 in cycle 1, lane1=0x22 in cycle 2, lane2=0x33 in cycle 3, lane3=0x44 in cycle 4.
   - done=1 only in cycle 4; in_ready=0 in cycles 1-4.
2. Stream 3 vectors lane r = 0x10*v+r, v=1..3, in cycles 0-2 (last on v=3). Required:
   - lane r shows v in cycle v+r; out-of-window cycles read 0 with lane_vld=0.
   - done in cycle 6.
3. Bubble: accepts in cycles 0 and 2, none in cycle 1. Required: every lane shows a zero/invalid gap exactly one cycle wide between the two vectors.
4. Drain backpressure: hold in_valid=1 with new data during DRAIN. Required: no accept until cycle k+5, then the new tile proceeds normally.
5. Assert reset_n=0 asynchronously mid-DRAIN. Required: outputs and lane_vld go to 0 without waiting for a clock edge; state IDLE; in_ready=1; no done pulse.
6. ARR_HEIGHT=1, one vector with last. Required: output in cycle 1, done in cycle 1, IDLE in cycle 2.
